univ_shift_reg: RTL

- Parametrised universal shift register: DEPTH stages, each WIDTH bits wide.
- Modes: hold, shift up, shift down, parallel load.
- Frame counter flags every DEPTH accepted shifts.
- Used as the general serial/parallel converter (SISO/SIPO/PISO/PIPO) for serial-link and test-pattern datapaths.

---
 rtl/univ_shift_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal DEPTH x WIDTH shift register (hold / shift up / shift down / parallel load) with frame pulse.
// Define SHREG_ROTATE_EN to make the rot input recirculate the outgoing end stage on shifts.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       sin_up,
    input  logic [WIDTH-1:0]       sin_dn,
    input  logic                   rot,
    input  logic [DEPTH*WIDTH-1:0] pin,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic [WIDTH-1:0]       sout_up,
    output logic [WIDTH-1:0]       sout_dn,
    output logic                   frame_done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int unsigned CW = $clog2(DEPTH);

    // Packed so that stage i sits at bits [i*WIDTH +: WIDTH], matching pin/pout.
    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [CW-1:0]               cnt;
    logic [WIDTH-1:0]            up_in;
    logic [WIDTH-1:0]            dn_in;
    mode_t                       op;

    always_comb begin
        op = MODE_HOLD;
        if (en) op = mode_t'(mode);
    end

`ifdef SHREG_ROTATE_EN
    always_comb begin
        up_in = rot ? stage[DEPTH-1] : sin_up;
        dn_in = rot ? stage[0]       : sin_dn;
    end
`else
    logic unused_rot;
    assign unused_rot = rot;

    always_comb begin
        up_in = sin_up;
        dn_in = sin_dn;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stage      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (op)
                MODE_UP: begin
                    stage[DEPTH-1:1] <= stage[DEPTH-2:0];
                    stage[0]         <= up_in;
                end
                MODE_DN: begin
                    stage[DEPTH-2:0] <= stage[DEPTH-1:1];
                    stage[DEPTH-1]   <= dn_in;
                end
                MODE_LOAD: begin
                    stage <= pin;
                    cnt   <= '0;
                end
                default: ;
            endcase
            if (op == MODE_UP || op == MODE_DN) begin
                if (cnt == CW'(DEPTH - 1)) begin
                    cnt        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign pout    = stage;
    assign sout_up = stage[DEPTH-1];
    assign sout_dn = stage[0];

endmodule
